// File: rtl/lopca_pkg.sv
// Shared types and helpers for the locked lower-part-OR carry-lookahead adder.
// Group-level CLA primitive and key-difference folding used to build the corruption mask.
package lopca_pkg;

  localparam int MAX_KEY_W  = 64;
  localparam int MAX_MASK_W = 64;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LOWER  = 4;
  localparam int NGROUPS    = (DEF_WIDTH - DEF_LOWER + 3) / 4;

  typedef struct packed {
    logic [3:0] sum;
    logic       g;
    logic       p;
  } cla_t;

  // Bit i of the key difference lands in mask bit (i mod width); zero-padding is implicit.
  function automatic logic [MAX_MASK_W-1:0] fold_mask(input logic [MAX_KEY_W-1:0] diff,
                                                      input int width);
    logic [MAX_MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEY_W; i++) begin
      m[6'(i % width)] = m[6'(i % width)] ^ diff[6'(i)];
    end
    return m;
  endfunction

  function automatic cla_t cla_group(input logic [3:0] a4, input logic [3:0] b4, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    cla_t       r;
    g    = a4 & b4;
    p    = a4 ^ b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    r.sum = p ^ c;
    r.g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p   = &p;
    return r;
  endfunction

endpackage

// File: rtl/lopca_key_ctrl.sv
// Key register, wrong-key counter with sticky lockout, registered unlock flag and result mask.
// Key loads take effect the next cycle; unlocked_o follows key_reg one cycle later.
module lopca_key_ctrl
  import lopca_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               KEY_W       = 32,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 32'h1430BAF1,
  parameter int               MAX_FAIL    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] keyinput_i,
  input  logic             key_load_i,
  output logic [WIDTH:0]   mask_o,
  output logic             unlocked_o,
  output logic             lockout_o
);

  localparam int            FW       = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FAIL_SAT = FW'(MAX_FAIL);

  logic [KEY_W-1:0]      key_q, key_d;
  logic [FW-1:0]         fail_cnt_q, fail_cnt_d;
  logic                  lockout_q, lockout_d;
  logic                  unlocked_q, unlocked_d;
  logic [MAX_MASK_W-1:0] fold_full;
  logic                  unused_fold;

  always_comb begin
    key_d      = key_q;
    fail_cnt_d = fail_cnt_q;
    if (key_load_i && !lockout_q) begin
      key_d = keyinput_i;
      if (keyinput_i != CORRECT_KEY) begin
        if (fail_cnt_q != FAIL_SAT) fail_cnt_d = fail_cnt_q + 1'b1;
      end else begin
        fail_cnt_d = '0;
      end
    end
    lockout_d  = lockout_q || (fail_cnt_d == FAIL_SAT);
    unlocked_d = (key_q == CORRECT_KEY) && !lockout_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q      <= '0;
      fail_cnt_q <= '0;
      lockout_q  <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      key_q      <= key_d;
      fail_cnt_q <= fail_cnt_d;
      lockout_q  <= lockout_d;
      unlocked_q <= unlocked_d;
    end
  end

  assign fold_full   = fold_mask(MAX_KEY_W'(key_q ^ CORRECT_KEY), WIDTH + 1);
  assign unused_fold = ^fold_full[MAX_MASK_W-1:WIDTH+1];
  assign mask_o      = lockout_q ? '1 : fold_full[WIDTH:0];
  assign unlocked_o  = unlocked_q;
  assign lockout_o   = lockout_q;

endmodule

// File: rtl/lopca_locked_adder_pipe.sv
// Key-locked approximate adder: OR on the low bits, 4-bit-group CLA above, result XOR-masked by key.
// Latency PIPE cycles, one result per cycle; stalls hold every stage, in_ready_o follows out_ready_i combinationally.
module lopca_locked_adder_pipe
  import lopca_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               LOWER       = 4,
  parameter int               KEY_W       = 32,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 32'h1430BAF1,
  parameter int               PIPE        = 2,
  parameter int               MAX_FAIL    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [KEY_W-1:0] keyinput_i,
  input  logic             key_load_i,
  output logic [WIDTH:0]   result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             unlocked_o,
  output logic             lockout_o
);

  localparam int UW   = WIDTH - LOWER;
  localparam int NGRP = (UW + 3) / 4;
  localparam int PW   = NGRP * 4;

  typedef struct packed {
    logic [PW-1:0]    a_hi;
    logic [PW-1:0]    b_hi;
    logic [LOWER-1:0] low;
    logic             cin;
    logic [NGRP-1:0]  g;
    logic [NGRP-1:0]  p;
    logic [WIDTH:0]   mask;
  } s1_t;

  logic [WIDTH:0] mask;
  s1_t            s1_new;
  s1_t            s1_use;
  cla_t           grp_pre [NGRP];
  cla_t           grp_fin [NGRP];
  logic [NGRP:0]  gc;
  logic [PW-1:0]  hsum;
  logic [PW:0]    hfull;
  logic [WIDTH:0] res_calc;
  logic           unused_grp;

  lopca_key_ctrl #(
    .WIDTH      (WIDTH),
    .KEY_W      (KEY_W),
    .CORRECT_KEY(CORRECT_KEY),
    .MAX_FAIL   (MAX_FAIL)
  ) u_key_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .keyinput_i(keyinput_i),
    .key_load_i(key_load_i),
    .mask_o    (mask),
    .unlocked_o(unlocked_o),
    .lockout_o (lockout_o)
  );

  // Front half: split operands and precompute per-group generate/propagate.
  always_comb begin
    s1_new      = '0;
    s1_new.a_hi = PW'(add1_i[WIDTH-1:LOWER]);
    s1_new.b_hi = PW'(add2_i[WIDTH-1:LOWER]);
    s1_new.low  = add1_i[LOWER-1:0] | add2_i[LOWER-1:0];
    s1_new.cin  = add1_i[LOWER-1] & add2_i[LOWER-1];
    s1_new.mask = mask;
    for (int g = 0; g < NGRP; g++) begin
      grp_pre[g]  = cla_group(s1_new.a_hi[4*g +: 4], s1_new.b_hi[4*g +: 4], 1'b0);
      s1_new.g[g] = grp_pre[g].g;
      s1_new.p[g] = grp_pre[g].p;
    end
  end

  // Back half: inter-group carries from G/P, then group sums with their real carry-in.
  always_comb begin
    gc    = '0;
    hsum  = '0;
    gc[0] = s1_use.cin;
    for (int g = 0; g < NGRP; g++) begin
      gc[g+1]        = s1_use.g[g] | (s1_use.p[g] & gc[g]);
      grp_fin[g]     = cla_group(s1_use.a_hi[4*g +: 4], s1_use.b_hi[4*g +: 4], gc[g]);
      hsum[4*g +: 4] = grp_fin[g].sum;
    end
    hfull    = {gc[NGRP], hsum};
    res_calc = {hfull[UW:0], s1_use.low} ^ s1_use.mask;
  end

  always_comb begin
    unused_grp = 1'b0;
    for (int g = 0; g < NGRP; g++) begin
      unused_grp = unused_grp ^ (^grp_pre[g].sum) ^ grp_fin[g].g ^ grp_fin[g].p;
    end
  end

  if (PIPE == 1) begin : g_pipe1
    logic           out_vld_q, out_vld_d;
    logic [WIDTH:0] res_q, res_d;
    logic           out_adv;

    assign s1_use     = s1_new;
    assign out_adv    = !out_vld_q || out_ready_i;
    assign in_ready_o = out_adv;

    always_comb begin
      out_vld_d = out_vld_q;
      res_d     = res_q;
      if (out_adv) begin
        out_vld_d = in_valid_i;
        if (in_valid_i) res_d = res_calc;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        out_vld_q <= 1'b0;
        res_q     <= '0;
      end else begin
        out_vld_q <= out_vld_d;
        res_q     <= res_d;
      end
    end

    assign out_valid_o = out_vld_q;
    assign result_o    = res_q;
  end else begin : g_pipe2
    s1_t            s1_q, s1_d;
    logic           s1_vld_q, s1_vld_d;
    logic           out_vld_q, out_vld_d;
    logic [WIDTH:0] res_q, res_d;
    logic           out_adv;
    logic           accept;

    assign s1_use     = s1_q;
    assign out_adv    = !out_vld_q || out_ready_i;
    assign in_ready_o = !s1_vld_q || out_adv;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_d      = s1_q;
      out_vld_d = out_vld_q;
      res_d     = res_q;
      if (accept) begin
        s1_vld_d = 1'b1;
        s1_d     = s1_new;
      end else if (s1_vld_q && out_adv) begin
        s1_vld_d = 1'b0;
      end
      if (out_adv) begin
        out_vld_d = s1_vld_q;
        if (s1_vld_q) res_d = res_calc;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_q      <= '0;
        s1_vld_q  <= 1'b0;
        out_vld_q <= 1'b0;
        res_q     <= '0;
      end else begin
        s1_q      <= s1_d;
        s1_vld_q  <= s1_vld_d;
        out_vld_q <= out_vld_d;
        res_q     <= res_d;
      end
    end

    assign out_valid_o = out_vld_q;
    assign result_o    = res_q;
  end

endmodule
